// File: rtl/display_scan_pwm.sv
// Time-multiplexed 7-segment scanner with 16-level brightness PWM and per-digit blink.
// Inputs are shadowed once per frame, so a frame never mixes old and new digit data.
module display_scan_pwm #(
  parameter int N_DIGITS     = 8,
  parameter int SUB_DIV      = 6250,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [6*N_DIGITS-1:0]   digits,
  input  logic [N_DIGITS-1:0]     blink,
  input  logic [3:0]              bright,
  output logic [7:0]              dec_cat,
  output logic [N_DIGITS-1:0]     an,
  output logic                    frame_start
);

  localparam int SW = (SUB_DIV > 1)      ? $clog2(SUB_DIV)      : 1;
  localparam int DW = (N_DIGITS > 1)     ? $clog2(N_DIGITS)     : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SW-1:0] SUB_LAST   = SW'(SUB_DIV - 1);
  localparam logic [DW-1:0] SLOT_LAST  = DW'(N_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic [SW-1:0] sub_cnt;
  logic [3:0]    phase;
  logic [DW-1:0] slot;
  logic [FW-1:0] frame_cnt;
  logic          blink_state;

  logic [N_DIGITS-1:0][5:0] sh_digits;
  logic [N_DIGITS-1:0]      sh_blink;
  logic [3:0]               sh_bright;

  logic sub_wrap, ph_wrap, slot_wrap, fr_wrap, frame_zero;

  assign sub_wrap   = (sub_cnt == SUB_LAST);
  assign ph_wrap    = sub_wrap && (phase == 4'd15);
  assign slot_wrap  = ph_wrap && (slot == SLOT_LAST);
  assign fr_wrap    = slot_wrap && (frame_cnt == FRAME_LAST);
  assign frame_zero = (sub_cnt == '0) && (phase == 4'd0) && (slot == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      sub_cnt     <= '0;
      phase       <= '0;
      slot        <= '0;
      frame_cnt   <= '0;
      blink_state <= 1'b0;
    end else begin
      sub_cnt <= sub_wrap ? '0 : sub_cnt + SW'(1);
      if (sub_wrap)  phase <= phase + 4'd1;
      if (ph_wrap)   slot  <= (slot == SLOT_LAST) ? '0 : slot + DW'(1);
      if (slot_wrap) frame_cnt <= fr_wrap ? '0 : frame_cnt + FW'(1);
      if (fr_wrap)   blink_state <= ~blink_state;
    end
  end

  // Shadow capture happens only on the last cycle of a frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      sh_digits <= '0;
      sh_blink  <= '0;
      sh_bright <= '0;
    end else if (slot_wrap) begin
      sh_digits <= digits;
      sh_blink  <= blink;
      sh_bright <= bright;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic                phase_on;
  logic [N_DIGITS-1:0] lane_lit;
  logic [N_DIGITS-1:0] an_nxt;
  logic [5:0]          sel;
  logic [7:0]          dc_nxt;

  // phase 15 can never satisfy phase < bright, which gives the ghost-blanking gap.
  assign phase_on = (phase < sh_bright);

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_lane
    assign lane_lit[i] = sh_digits[i][5] && (slot == DW'(i)) && !(sh_blink[i] && blink_state);
    assign an_nxt[N_DIGITS-1-i] = ~(lane_lit[i] & phase_on);
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_DIGITS; i++)
      if (slot == DW'(i)) sel = sh_digits[i];
  end

  assign dc_nxt = ((|lane_lit) && phase_on) ? {seg7(sel[4:1]), ~sel[0]} : 8'hFF;

  always_ff @(posedge clock) begin
    if (reset) begin
      an          <= '1;
      dec_cat     <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      an          <= an_nxt;
      dec_cat     <= dc_nxt;
      frame_start <= frame_zero;
    end
  end

endmodule

// File: tb/tb_display_scan_pwm.sv
// Scoreboard bench for display_scan_pwm: a cycle-count reference model predicts every output cycle.
module tb_display_scan_pwm;
  localparam int N = 4, SD = 2, BF = 2;
  localparam int SLOT_C = 16 * SD, FRAME_C = SLOT_C * N;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] digits;
  logic [3:0]  blink, bright;
  logic [7:0]  dec_cat;
  logic [3:0]  an;
  logic        frame_start;

  always #5 clock = ~clock;

  display_scan_pwm #(.N_DIGITS(N), .SUB_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clock(clock), .reset(reset), .digits(digits), .blink(blink), .bright(bright),
    .dec_cat(dec_cat), .an(an), .frame_start(frame_start));

  typedef struct { logic [3:0] an; logic [7:0] dc; logic fs; } exp_t;
  exp_t q[$];

  int n_chk = 0, n_fail = 0;
  int mt = 0;
  logic [23:0] m_dig = '0;
  logic [3:0]  m_blk = '0, m_brt = '0;
  logic [6:0]  SEG [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: mt is the cycle index since reset; everything derives from it arithmetically.
  initial forever begin
    exp_t e;
    int ph, sl, fr;
    logic [5:0] d;
    logic lit;
    logic [3:0] a;
    @(posedge clock);
    if (reset) begin
      e.an = 4'hF; e.dc = 8'hFF; e.fs = 1'b0;
      mt = 0; m_dig = '0; m_blk = '0; m_brt = '0;
    end else begin
      ph = (mt / SD) % 16;
      sl = (mt / SLOT_C) % N;
      fr = mt / FRAME_C;
      d  = m_dig[sl*6 +: 6];
      lit = d[5] && (ph < int'(m_brt)) && !(m_blk[sl] && ((fr / BF) % 2 == 1));
      a = 4'hF;
      a[N-1-sl] = 1'b0;
      e.an = lit ? a : 4'hF;
      e.dc = lit ? {SEG[d[4:1]], ~d[0]} : 8'hFF;
      e.fs = (mt % FRAME_C == 0);
      if (mt % FRAME_C == FRAME_C - 1) begin
        m_dig = digits; m_blk = blink; m_brt = bright;
      end
      mt++;
    end
    q.push_back(e);
  end

  // Monitor: one output per cycle, compared just after the edge.
  initial forever begin
    exp_t e;
    @(posedge clock);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (an !== e.an || dec_cat !== e.dc || frame_start !== e.fs) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got an=%b dec_cat=%b fs=%b, want an=%b dec_cat=%b fs=%b",
                 $time, an, dec_cat, frame_start, e.an, e.dc, e.fs);
      end
      n_chk++;
      if ($countones(~an) > 1) begin
        n_fail++;
        $display("FAIL one_anode t=%0t: got an=%b, want at most one low bit", $time, an);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_pos(input int p);
    int k = 0;
    while (mt % FRAME_C != p && k < 2 * FRAME_C) begin
      @(negedge clock);
      k++;
    end
    n_chk++;
    if (k >= 2 * FRAME_C) begin
      n_fail++;
      $display("FAIL wait_pos: got no frame position %0d within %0d cycles, want it reached", p, k);
    end
  endtask

  initial begin
    digits = {1'b1, 4'd4, 1'b0, 1'b1, 4'd3, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd1, 1'b0};
    blink  = 4'b0000;
    bright = 4'd15;
    reset  = 1'b1;
    run(2);
    reset = 1'b0;
    run(3 * FRAME_C);                         // dark frame 1, then full-bright scan
    bright = 4'd4;  run(2 * FRAME_C);         // dimming
    bright = 4'd0;  run(2 * FRAME_C);         // fully dark
    bright = 4'd15; blink = 4'b0001; run(6 * FRAME_C);
    blink = 4'b0000;
    wait_pos(SLOT_C + 8);                     // middle of slot 1
    digits[2*6+1 +: 4] = 4'd9;
    run(2 * FRAME_C);
    wait_pos(FRAME_C - 1);                    // change on end-of-frame cycle is captured
    digits[1 +: 4] = 4'd7;
    @(negedge clock);
    digits[1 +: 4] = 4'd8;                    // one cycle later waits a frame
    digits[0] = 1'b1;
    run(2 * FRAME_C);
    wait_pos(2 * SLOT_C + 6);                 // reset during slot 2
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    run(3 * FRAME_C);
    repeat (20 * FRAME_C) begin
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) digits = 24'($urandom);
      if ($urandom_range(0, 79) == 0) blink  = 4'($urandom);
      if ($urandom_range(0, 59) == 0) bright = 4'($urandom);
      reset = ($urandom_range(0, 1999) == 0);
    end
    reset = 1'b0;
    run(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_pwm.md
# display_scan_pwm

Parametrised time-multiplexed driver for common-anode 7-segment banks: scans `N_DIGITS` digits, dims them with a 16-level brightness PWM and blinks selected digits. Digit data is captured in shadow registers once per frame, so a frame never mixes old and new values. It sits between the alarm/clock logic and the board's `an`/`dec_cat` pins and generalises the fixed 8-digit scanner.

## Interface
- `N_DIGITS`, 8, digit count; legal range 1..16.
- `SUB_DIV`, 6250, clock cycles per PWM sub-phase; ≥1. One slot is 16 sub-phases (1 ms at 100 MHz).
- `BLINK_FRAMES`, 64, frames per blink half-period; ≥1.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `digits`  in  6*N_DIGITS  digit i in bits [6i+5:6i]: [5] enable, [4:1] hex value, [0] decimal point (1 = lit).
- `blink`  in  N_DIGITS  bit i = 1 makes digit i blink.
- `bright`  in  4  duty in sixteenths; 0 = dark, 15 = 15/16.
- `dec_cat`  out  8  active-low cathodes {g,f,e,d,c,b,a,dp}; registered.
- `an`  out  N_DIGITS  active-low anodes; digit i drives `an[N_DIGITS-1-i]`; registered.
- `frame_start`  out  1  one-cycle pulse marking the first output cycle of slot 0.

## Operation
- Counters:
  - `sub_cnt` counts 0..SUB_DIV-1.
  - `phase` counts 0..15 and advances when `sub_cnt` wraps.
  - `slot` counts 0..N_DIGITS-1 and advances when `phase` wraps.
  - `frame_cnt` counts 0..BLINK_FRAMES-1 and advances when `slot` wraps.
  - `blink_state` toggles when `frame_cnt` wraps.
  - Each counter is $clog2-sized, with a minimum width of 1.
- End-of-frame cycle (`slot`=N-1, `phase`=15, `sub_cnt`=SUB_DIV-1): `digits`, `blink` and `bright` are loaded into shadow registers. Input changes at any other time are invisible until the next frame.
- Digit `slot` is lit iff all three hold:
  - shadow enable = 1;
  - `phase` < shadow `bright`;
  - NOT (shadow blink bit = 1 AND `blink_state` = 1).
- When lit:
  - `an` = all ones except bit N-1-slot, which is 0.
  - `dec_cat[7:1]` = segment table[value].
  - `dec_cat[0]` = ~dp.
- When not lit: `an` = all ones and `dec_cat` = 8'hFF (cathodes blanked as well as the anode).
- Segment table, {g..a} active-low, values 0..F: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- At most one anode bit is ever 0.
- Every slot ends with at least one dark sub-phase (`phase`=15 is always dark). This is the inter-digit ghost blanking.

## Timing
- Reset values:
  - `an` = all ones, `dec_cat` = 8'hFF, `frame_start` = 0.
  - All counters = 0, `blink_state` = 0.
  - Shadow registers = 0, i.e. all digits disabled and `bright` = 0.
- Reset asserted mid-frame: outputs reach their reset values on the next edge, and counters restart at slot 0.
- The first frame after reset is fully dark, because the shadow registers are zero. Inputs captured at its end are shown from frame 2 onward.
- Latency: the counter state in cycle t determines `an`/`dec_cat` in cycle t+1.
- `frame_start` is 1 in the cycle after the counters are all zero (coincident with the first slot-0 output), and 0 otherwise. It does not pulse in the cycle that reset is asserted.
- Frame period = 16·SUB_DIV·N_DIGITS cycles. Blink half-period = BLINK_FRAMES frames.
- Shadow-load timing vs. inputs:
  - An input change in the end-of-frame cycle itself is captured.
  - A change one cycle later waits a full frame.
- Wrap-around: counters roll over freely, with no idle gap between frames.

## Test plan
Bench parameters: N_DIGITS=4, SUB_DIV=2, BLINK_FRAMES=2 (slot = 32 cycles, frame = 128 cycles).

- **Reset and frame 1:**
  - Stimulus: `digits` = all enabled with values 1,2,3,4; dp=0; `bright`=15; `blink`=0.
  - Required: `an`=4'hF and `dec_cat`=8'hFF for all of frame 1; `frame_start` pulses every 128 cycles.
- **Scan and brightness:**
  - Stimulus: same as above, observed from frame 2.
  - Required: slot 0 shows `an`=4'b0111 and `dec_cat`=8'b11110011 for 30 cycles, then 2 dark cycles.
  - Required: slot 3 shows `an`=4'b1110 and `dec_cat`=8'b00110011.
- **Dimming:**
  - Stimulus: `bright`=4.
  - Required: each digit is lit for exactly 8 of its 32 cycles.
  - Required: `bright`=0 gives a fully dark frame.
- **Blink:**
  - Stimulus: `blink`=4'b0001.
  - Required: digit 0 is dark in frames where `blink_state`=1 and lit otherwise, toggling every 2 frames; digits 1..3 are unaffected.
- **Tear-free update:**
  - Stimulus: change digit 2's value in the middle of slot 1.
  - Required: the old value is shown for the rest of that frame; the new value appears from the next `frame_start`.
- **Mid-frame reset:**
  - Stimulus: assert `reset` for 1 cycle during slot 2.
  - Required: next cycle `an`=4'hF and `dec_cat`=8'hFF; the following frame is dark; normal display resumes one frame later.
